serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on the accepting edge.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result bits.
REQ-011 The block SHALL have port cout, output, 1 bit: registered final carry-out.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one instance of the existing full_adder module and no other adder logic.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, encoded in a registered state variable.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and cin into internal registers, clear the bit counter and enter RUN.
REQ-015 In IDLE with start=0, the state SHALL remain IDLE and all outputs SHALL hold.
REQ-016 In RUN, each edge SHALL feed the full_adder with the current LSBs of the A and B shift registers and the carry register.
REQ-017 On each RUN edge, the block SHALL shift the sum bit into the result shift register from the MSB side, load the carry register from the adder carry-out, shift A and B right by one and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the block SHALL enter DONE and load sum and cout from the result and carry registers.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; on the next edge the state SHALL return to IDLE unconditionally.
REQ-020 Latency: if start is sampled at edge E, done SHALL be high in the cycle following edge E+WIDTH; minimum start-to-start period SHALL be WIDTH+2 cycles.
REQ-021 start SHALL be ignored in RUN and DONE; a, b and cin changes after capture SHALL NOT affect the result.
REQ-022 sum and cout SHALL hold the last result until the next DONE entry.
REQ-023 busy SHALL be 1 in RUN only; busy and done SHALL never both be 1.
REQ-024 WIDTH=1 SHALL give one RUN cycle with correct sum and cout.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force state=IDLE and busy=0, done=0, sum=0, cout=0, and clear the counter, carry, operand and result registers.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-027 The first edge after rst deasserts SHALL sample start normally.

Verification (WIDTH=8 unless stated)
REQ-028 start with a=8'h00, b=8'h00, cin=0 -> busy high for 8 cycles, then done pulse; sum=8'h00, cout=0.
REQ-029 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-030 a=8'h5A, b=8'hA5, cin=0, then during RUN change a to 8'h00 and pulse start -> sum=8'hFF, cout=0, a single done pulse, period unchanged.
REQ-031 Assert rst asynchronously on the 4th RUN cycle -> busy/done/sum/cout go to 0 before the next edge and no done pulse occurs; a following start with 8'h03+8'h04 gives sum=8'h07.
REQ-032 Hold start=1 continuously -> done pulses exactly every 10 cycles.
REQ-033 Exhaustively check a, b in 0..3 and cin in 0..1 with WIDTH=2 -> {cout,sum} equals a+b+cin for all 32 cases.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder controller. Computes {cout,sum} = a + b + cin one bit per
//   clock, LSB first, through a single full_adder instance.
//
//   Operation: IDLE waits for start, then captures the operands. RUN performs
//   WIDTH add steps. DONE presents a one-cycle done pulse, after which the FSM
//   returns to IDLE.
//
//   Ports
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset
//     start : begin an addition (sampled only in IDLE)
//     a, b  : WIDTH-bit operands, captured on the accepting edge
//     cin   : carry-in, captured on the accepting edge
//     busy  : high while the FSM is in RUN
//     done  : one-cycle pulse marking a new valid result
//     sum   : registered result bits (held until the next result)
//     cout  : registered final carry-out
// -----------------------------------------------------------------------------

// Single-bit full adder; the only adder used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH-1:0]   res_next;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the first (LSB) bit has
  // reached position 0. Written as a shifted concatenation so WIDTH=1 works.
  assign res_next = WIDTH'({fa_sum, res_sr} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          res_sr <= res_next;
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Final step: outputs take the values the registers are being
          // loaded with on this same edge.
          if (cnt == LAST_CNT) begin
            sum   <= res_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl. Three instances share one clock
//   and reset: WIDTH=8 (main), WIDTH=2 (exhaustive) and WIDTH=1 (edge case).
//   Expected results come from plain integer addition a + b + cin; expected
//   timing comes from the latency rule (done in the cycle after edge E+WIDTH,
//   start-to-start period WIDTH+2).
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  // WIDTH=2 instance
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Launches one WIDTH=8 addition and follows it until done (bounded).
  // lat is the index of the negedge after the accepting edge at which done is
  // seen (1 = first cycle after acceptance); 0 means it never came.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        output logic [8:0] res, output int busy_n, output int lat);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy8) busy_n++;
      if (done8) begin lat = i; break; end
      @(negedge clk);
    end
    res = {cout8, sum8};
  endtask

  task automatic do_op2(input logic [1:0] av, input logic [1:0] bv, input logic ci,
                        output logic [2:0] res, output int lat);
    @(negedge clk);
    a2 = av; b2 = bv; cin2 = ci; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done2) begin lat = i; break; end
      @(negedge clk);
    end
    res = {cout2, sum2};
  endtask

  task automatic do_op1(input logic av, input logic bv, input logic ci,
                        output logic [1:0] res, output int lat);
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done1) begin lat = i; break; end
      @(negedge clk);
    end
    res = {cout1, sum1};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      fails++;
      $display("[TB] FAIL reset_w8: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy8, done8, sum8, cout8);
    end
    tests++;
    if ({busy2, done2, cout2, sum2, busy1, done1, cout1, sum1} !== 9'd0) begin
      fails++;
      $display("[TB] FAIL reset_w2w1: got w2 busy=%b done=%b sum=%h cout=%b w1 busy=%b done=%b sum=%b cout=%b, want all 0",
               busy2, done2, sum2, cout2, busy1, done1, sum1, cout1);
    end
    @(negedge clk);
    rst = 1'b0;
    // Idle with start low: nothing should move.
    repeat (3) @(negedge clk);
    tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) begin
      fails++;
      $display("[TB] FAIL idle_hold: got busy=%b done=%b sum=%h, want 0 0 00", busy8, done8, sum8);
    end
  endtask

  task automatic test_zero();
    logic [8:0] res;
    int busy_n, lat;
    do_op8(8'h00, 8'h00, 1'b0, res, busy_n, lat);
    tests++;
    if (busy_n !== 8 || lat !== 9) begin
      fails++;
      $display("[TB] FAIL zero_timing: got busy_cycles=%0d done_at=%0d, want 8 and 9", busy_n, lat);
    end
    tests++;
    if (res !== 9'h000) begin
      fails++;
      $display("[TB] FAIL zero_result: got %h, want 000", res);
    end
    @(negedge clk);
    tests++;
    if (done8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL done_width: got done=%b one cycle later, want 0", done8);
    end
  endtask

  task automatic test_corners();
    logic [8:0] res;
    int busy_n, lat;
    do_op8(8'hFF, 8'h01, 1'b0, res, busy_n, lat);
    tests++;
    if (res !== 9'h100 || lat !== 9) begin
      fails++;
      $display("[TB] FAIL ff_plus_01: got %h at %0d, want 100 at 9", res, lat);
    end
    do_op8(8'hFF, 8'hFF, 1'b1, res, busy_n, lat);
    tests++;
    if (res !== 9'h1FF || lat !== 9) begin
      fails++;
      $display("[TB] FAIL ff_plus_ff_c: got %h at %0d, want 1ff at 9", res, lat);
    end
  endtask

  task automatic test_random();
    logic [8:0] res, exp;
    logic [7:0] av, bv;
    logic ci;
    int busy_n, lat;
    for (int n = 0; n < 20; n++) begin
      av = 8'($urandom); bv = 8'($urandom); ci = 1'($urandom);
      exp = 9'(int'(av) + int'(bv) + int'(ci));
      do_op8(av, bv, ci, res, busy_n, lat);
      tests++;
      if (res !== exp || lat !== 9 || busy_n !== 8) begin
        fails++;
        $display("[TB] FAIL random_%0d: %h+%h+%b got %h (done_at=%0d busy=%0d), want %h (9, 8)",
                 n, av, bv, ci, res, lat, busy_n, exp);
      end
    end
  endtask

  task automatic test_ignore_inputs();
    int busy_n = 0, dn = 0, lat = 0;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) start8 = 1'b1;
      if (i == 4) start8 = 1'b0;
      if (busy8) busy_n++;
      if (done8) begin dn++; if (lat == 0) lat = i; end
      @(negedge clk);
    end
    tests++;
    if (sum8 !== 8'hFF || cout8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL late_change_result: got sum=%h cout=%b, want ff 0", sum8, cout8);
    end
    tests++;
    if (dn !== 1 || lat !== 9 || busy_n !== 8) begin
      fails++;
      $display("[TB] FAIL start_in_run: got pulses=%0d done_at=%0d busy=%0d, want 1 9 8", dn, lat, busy_n);
    end
  endtask

  task automatic test_reset_abort();
    logic [8:0] res;
    int busy_n, lat, dn = 0;
    do_op8(8'h12, 8'h34, 1'b0, res, busy_n, lat);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy8 !== 1'b1 || sum8 !== 8'h46) begin
      fails++;
      $display("[TB] FAIL pre_abort: got busy=%b sum=%h, want 1 46", busy8, sum8);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_abort: got busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done8) dn++;
      @(negedge clk);
    end
    tests++;
    if (dn !== 0) begin
      fails++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses, want 0", dn);
    end
    do_op8(8'h03, 8'h04, 1'b0, res, busy_n, lat);
    tests++;
    if (res !== 9'h007 || lat !== 9) begin
      fails++;
      $display("[TB] FAIL after_abort: got %h at %0d, want 007 at 9", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    logic [7:0] av, bv;
    logic [8:0] exp;
    int overlap = 0, bad_res = 0, gap_bad = 0;
    av = 8'($urandom); bv = 8'($urandom);
    exp = 9'(int'(av) + int'(bv) + 1);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = 1'b1; start8 = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy8 && done8) overlap++;
      if (done8) begin
        pulses.push_back(i);
        if ({cout8, sum8} !== exp) bad_res++;
      end
    end
    start8 = 1'b0;
    for (int k = 1; k < pulses.size(); k++)
      if (pulses[k] - pulses[k-1] != 10) gap_bad++;
    tests++;
    if (pulses.size() < 5 || gap_bad != 0) begin
      fails++;
      $display("[TB] FAIL period: got %0d pulses with %0d bad gaps, want >=5 spaced 10", pulses.size(), gap_bad);
    end
    tests++;
    if (overlap != 0 || bad_res != 0) begin
      fails++;
      $display("[TB] FAIL b2b_result: got overlap=%0d bad_results=%0d, want 0 0 (expected %h)", overlap, bad_res, exp);
    end
    // Drain to IDLE (neither busy nor done) within a bounded window.
    for (int i = 0; i < 20 && (busy8 || done8); i++) @(negedge clk);
  endtask

  task automatic test_width2_exhaustive();
    logic [2:0] res, exp;
    int lat, bad = 0;
    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        for (int ci = 0; ci < 2; ci++) begin
          exp = 3'(av + bv + ci);
          do_op2(2'(av), 2'(bv), 1'(ci), res, lat);
          tests++;
          if (res !== exp || lat !== 3) begin
            fails++; bad++;
            $display("[TB] FAIL w2_%0d_%0d_%0d: got %h at %0d, want %h at 3", av, bv, ci, res, lat, exp);
          end
        end
  endtask

  task automatic test_width1();
    logic [1:0] res, exp;
    int lat;
    for (int v = 0; v < 8; v++) begin
      exp = 2'(v[2] + v[1] + v[0]);
      do_op1(v[2], v[1], v[0], res, lat);
      tests++;
      if (res !== exp || lat !== 2) begin
        fails++;
        $display("[TB] FAIL w1_%0d: got %b at %0d, want %b at 2", v, res, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_corners();
    test_random();
    test_ignore_inputs();
    test_reset_abort();
    test_back_to_back();
    test_width2_exhaustive();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
